// File: rtl/mmio_arbiter_pkg.sv
// Shared types for the MMIO port arbiter.
package mmio_enum;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDATA
  } mmio_arb_state_t;

endpackage

// File: rtl/mmio_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr, wrapping at N.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter sharing one MMIO register port between N_REQ requesters,
// one transaction in flight; all outputs registered.
module mmio_arbiter
  import mmio_enum::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned A_WIDTH = 32,
  parameter int unsigned D_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ-1:0]           we_i,
  input  logic [N_REQ*A_WIDTH-1:0]   addr_i,
  input  logic [N_REQ*D_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]           ack_o,
  output logic [N_REQ-1:0]           rvalid_o,
  output logic [D_WIDTH-1:0]         rdata_o,
  output logic                       wr_en_o,
  output logic [A_WIDTH-1:0]         wr_addr_o,
  output logic [D_WIDTH-1:0]         wr_data_o,
  output logic                       rd_en_o,
  output logic [A_WIDTH-1:0]         rd_addr_o,
  input  logic [D_WIDTH-1:0]         rd_data_i
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  mmio_arb_state_t    state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               we_q, we_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;

  logic [N_REQ-1:0]   ack_d, rvalid_d;
  logic [D_WIDTH-1:0] rdata_d;
  logic               wr_en_d, rd_en_d;
  logic [A_WIDTH-1:0] wr_addr_d, rd_addr_d;
  logic [D_WIDTH-1:0] wr_data_d;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req_i),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Strobes are computed one state early so they appear registered during ISSUE.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    we_d      = we_q;
    ptr_d     = ptr_q;
    ack_d     = '0;
    rvalid_d  = '0;
    rdata_d   = rdata_o;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    rd_en_d   = 1'b0;
    rd_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          id_d          = gnt_id;
          we_d          = we_i[gnt_id];
          ptr_d         = gnt_id;
          ack_d[gnt_id] = 1'b1;
          if (we_i[gnt_id]) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_i[32'(gnt_id)*A_WIDTH +: A_WIDTH];
            wr_data_d = wdata_i[32'(gnt_id)*D_WIDTH +: D_WIDTH];
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_i[32'(gnt_id)*A_WIDTH +: A_WIDTH];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = we_q ? IDLE : RDATA;
      RDATA: begin
        rdata_d        = rd_data_i;
        rvalid_d[id_q] = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      we_q      <= 1'b0;
      ptr_q     <= ID_W'(N_REQ - 1);
      ack_o     <= '0;
      rvalid_o  <= '0;
      rdata_o   <= '0;
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      rd_en_o   <= 1'b0;
      rd_addr_o <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      we_q      <= we_d;
      ptr_q     <= ptr_d;
      ack_o     <= ack_d;
      rvalid_o  <= rvalid_d;
      rdata_o   <= rdata_d;
      wr_en_o   <= wr_en_d;
      wr_addr_o <= wr_addr_d;
      wr_data_o <= wr_data_d;
      rd_en_o   <= rd_en_d;
      rd_addr_o <= rd_addr_d;
    end
  end

endmodule
